// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_write_arbiter : shares the RF write port between pipeline WB and an aux
//                    requester via a small FIFO with starvation-forced drain.
// Rev 1.0
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int PROC_BITS      = 32,
  parameter int REG_ADDRS_BITS = 5,
  parameter int AUX_DEPTH      = 2,
  parameter int MAX_WAIT       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wb_we,
  input  logic [REG_ADDRS_BITS-1:0] i_wb_addr,
  input  logic [PROC_BITS-1:0]      i_wb_data,
  input  logic                      i_aux_valid,
  input  logic [REG_ADDRS_BITS-1:0] i_aux_addr,
  input  logic [PROC_BITS-1:0]      i_aux_data,
  output logic                      o_aux_ready,
  output logic                      o_stall,
  output logic                      o_rf_we,
  output logic [REG_ADDRS_BITS-1:0] o_rf_addr,
  output logic [PROC_BITS-1:0]      o_rf_data
);

  localparam int PTR_W  = $clog2(AUX_DEPTH);
  localparam int CNT_W  = $clog2(AUX_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [REG_ADDRS_BITS-1:0] mem_addr_q [AUX_DEPTH];
  logic [PROC_BITS-1:0]      mem_data_q [AUX_DEPTH];

  logic w_empty, w_full, w_wb_eff, w_push, w_pop, w_rf_we;

  always_comb begin
    w_empty  = (count_q == '0);
    w_full   = (count_q == CNT_W'(AUX_DEPTH));
    w_wb_eff = i_wb_we && (i_wb_addr != '0);
    // Address-0 aux results complete the handshake but are never stored.
    w_push   = i_aux_valid && !w_full && (i_aux_addr != '0);
    w_pop    = !w_empty && ((state_q == ST_FORCE) || !w_wb_eff);
  end

  // Write-port mux: pipeline wins in IDLE, FIFO head wins in FORCE.
  always_comb begin
    w_rf_we   = 1'b0;
    o_rf_addr = '0;
    o_rf_data = '0;
    if (state_q == ST_FORCE) begin
      w_rf_we   = !w_empty;
      o_rf_addr = mem_addr_q[rd_ptr_q];
      o_rf_data = mem_data_q[rd_ptr_q];
    end else if (w_wb_eff) begin
      w_rf_we   = 1'b1;
      o_rf_addr = i_wb_addr;
      o_rf_data = i_wb_data;
    end else if (!w_empty) begin
      w_rf_we   = 1'b1;
      o_rf_addr = mem_addr_q[rd_ptr_q];
      o_rf_data = mem_data_q[rd_ptr_q];
    end
  end

  assign o_rf_we     = w_rf_we && !rst;
  assign o_stall     = (state_q == ST_FORCE);
  assign o_aux_ready = !w_full;

  always_comb begin
    state_d  = ST_IDLE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
    else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);

    if (w_empty || w_pop)                  wait_d = '0;
    else if (wait_q != WAIT_W'(MAX_WAIT)) wait_d = wait_q + WAIT_W'(1);

    // Starved head: steal the next cycle from the pipeline.
    if ((state_q == ST_IDLE) && !w_empty && !w_pop &&
        (wait_q == WAIT_W'(MAX_WAIT - 1)))
      state_d = ST_FORCE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_addr_q[wr_ptr_q] <= i_aux_addr;
      mem_data_q[wr_ptr_q] <= i_aux_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter : directed self-checking bench for rf_write_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_aux_valid;
  logic [4:0]  i_aux_addr;
  logic [31:0] i_aux_data;
  logic        o_aux_ready;
  logic        o_stall;
  logic        o_rf_we;
  logic [4:0]  o_rf_addr;
  logic [31:0] o_rf_data;

  int n_total;
  int n_bad;

  rf_write_arbiter #(
    .PROC_BITS      (32),
    .REG_ADDRS_BITS (5),
    .AUX_DEPTH      (2),
    .MAX_WAIT       (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_wb_we     (i_wb_we),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_aux_valid (i_aux_valid),
    .i_aux_addr  (i_aux_addr),
    .i_aux_data  (i_aux_data),
    .o_aux_ready (o_aux_ready),
    .o_stall     (o_stall),
    .o_rf_we     (o_rf_we),
    .o_rf_addr   (o_rf_addr),
    .o_rf_data   (o_rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    i_wb_we     = wv;
    i_wb_addr   = wa;
    i_wb_data   = wd;
    i_aux_valid = av;
    i_aux_addr  = aa;
    i_aux_data  = ad;
  endtask

  initial begin
    logic        c_done;
    logic        accept_now;
    logic        exp_force;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    n_total = 0;
    n_bad   = 0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #12;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_ready", 32'(o_aux_ready), 32'd1);
    chk("rst_rfwe", 32'(o_rf_we), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: pipeline write passes straight through
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t1_we", 32'(o_rf_we), 32'd1);
    chk("t1_addr", 32'(o_rf_addr), 32'd3);
    chk("t1_data", o_rf_data, 32'hA5A5A5A5);
    chk("t1_stall", 32'(o_stall), 32'd0);
    tick();

    // 2: idle pipeline drains aux entries one cycle after push
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    #1;
    chk("t2_c0_ready", 32'(o_aux_ready), 32'd1);
    chk("t2_c0_we", 32'(o_rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h22);
    #1;
    chk("t2_c1_ready", 32'(o_aux_ready), 32'd1);
    chk("t2_c1_we", 32'(o_rf_we), 32'd1);
    chk("t2_c1_addr", 32'(o_rf_addr), 32'd7);
    chk("t2_c1_data", o_rf_data, 32'h11);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_c2_ready", 32'(o_aux_ready), 32'd1);
    chk("t2_c2_we", 32'(o_rf_we), 32'd1);
    chk("t2_c2_addr", 32'(o_rf_addr), 32'd8);
    chk("t2_c2_data", o_rf_data, 32'h22);
    tick();
    #1;
    chk("t2_c3_we", 32'(o_rf_we), 32'd0);

    // 3: busy pipeline, single entry forced after 8 waiting cycles
    drive(1'b1, 5'd4, 32'h444, 1'b1, 5'd9, 32'h33);
    #1;
    chk("t3_c0_addr", 32'(o_rf_addr), 32'd4);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'd4, 32'h444, 1'b0, 5'd0, 32'h0);
      #1;
      chk($sformatf("t3_wait%0d_stall", i), 32'(o_stall), 32'd0);
      chk($sformatf("t3_wait%0d_addr", i), 32'(o_rf_addr), 32'd4);
      tick();
    end
    #1;
    chk("t3_force_stall", 32'(o_stall), 32'd1);
    chk("t3_force_we", 32'(o_rf_we), 32'd1);
    chk("t3_force_addr", 32'(o_rf_addr), 32'd9);
    chk("t3_force_data", o_rf_data, 32'h33);
    tick();
    #1;
    chk("t3_after_stall", 32'(o_stall), 32'd0);
    chk("t3_after_addr", 32'(o_rf_addr), 32'd4);
    chk("t3_after_data", o_rf_data, 32'h444);

    // 4: three pushes into depth-2 FIFO under continuous pipeline writes
    c_done = 1'b0;
    for (int i = 0; i <= 28; i++) begin
      accept_now = 1'b0;
      if (i == 0)      drive(1'b1, 5'd4, 32'h444, 1'b1, 5'd10, 32'hA1);
      else if (i == 1) drive(1'b1, 5'd4, 32'h444, 1'b1, 5'd11, 32'hB2);
      else             drive(1'b1, 5'd4, 32'h444, !c_done, 5'd12, 32'hC3);
      #1;
      exp_force = (i == 9) || (i == 18) || (i == 27);
      exp_addr  = (i == 9) ? 5'd10 : (i == 18) ? 5'd11 : (i == 27) ? 5'd12 : 5'd4;
      exp_data  = (i == 9) ? 32'hA1 : (i == 18) ? 32'hB2 : (i == 27) ? 32'hC3 : 32'h444;
      chk($sformatf("t4_c%0d_stall", i), 32'(o_stall), 32'(exp_force));
      chk($sformatf("t4_c%0d_addr", i), 32'(o_rf_addr), 32'(exp_addr));
      chk($sformatf("t4_c%0d_data", i), o_rf_data, exp_data);
      if (i == 1)  chk("t4_ready_c1", 32'(o_aux_ready), 32'd1);
      if (i == 2)  chk("t4_ready_c2", 32'(o_aux_ready), 32'd0);
      if (i == 9)  chk("t4_ready_c9", 32'(o_aux_ready), 32'd0);
      if (i == 10) chk("t4_ready_c10", 32'(o_aux_ready), 32'd1);
      if (i >= 2 && !c_done && o_aux_ready) begin
        accept_now = 1'b1;
        chk("t4_accept_cycle", 32'(i), 32'd10);
      end
      tick();
      if (accept_now) c_done = 1'b1;
    end
    chk("t4_c_accepted", 32'(c_done), 32'd1);

    // 5: pipeline write to r0 is ineffective; aux push to r0 is dropped
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h44);
    #1;
    chk("t5_push_ready", 32'(o_aux_ready), 32'd1);
    tick();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t5_r0_we", 32'(o_rf_we), 32'd1);
    chk("t5_r0_addr", 32'(o_rf_addr), 32'd5);
    chk("t5_r0_data", o_rf_data, 32'h44);
    chk("t5_r0_stall", 32'(o_stall), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    #1;
    chk("t5_aux0_ready", 32'(o_aux_ready), 32'd1);
    chk("t5_aux0_we", 32'(o_rf_we), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk($sformatf("t5_quiet%0d_we", i), 32'(o_rf_we), 32'd0);
      tick();
    end

    // 6: reset while in FORCE with a full FIFO
    for (int i = 0; i <= 9; i++) begin
      if (i == 0)      drive(1'b1, 5'd4, 32'h444, 1'b1, 5'd13, 32'hD1);
      else if (i == 1) drive(1'b1, 5'd4, 32'h444, 1'b1, 5'd14, 32'hD2);
      else             drive(1'b1, 5'd4, 32'h444, 1'b0, 5'd0, 32'h0);
      #1;
      if (i < 9) tick();
    end
    chk("t6_pre_stall", 32'(o_stall), 32'd1);
    chk("t6_pre_addr", 32'(o_rf_addr), 32'd13);
    chk("t6_pre_ready", 32'(o_aux_ready), 32'd0);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("t6_rst_stall", 32'(o_stall), 32'd0);
    chk("t6_rst_we", 32'(o_rf_we), 32'd0);
    chk("t6_rst_ready", 32'(o_aux_ready), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", 32'(o_aux_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("t6_idle%0d_we", i), 32'(o_rf_we), 32'd0);
      chk($sformatf("t6_idle%0d_stall", i), 32'(o_stall), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
